// File: rtl/ack_cts_responder_pkg.sv
// Shared xpu definitions for the ACK/CTS responder: FSM states, frame-control
// constants, legacy rate codes and the frame classifier.
package ack_cts_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RX_FIELDS,
    ST_SIFS_WAIT,
    ST_REQ
  } resp_state_t;

  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_ACK,
    CLS_CTS
  } resp_class_t;

  localparam logic [1:0]  FC_TYPE_MGMT   = 2'b00;
  localparam logic [1:0]  FC_TYPE_CTRL   = 2'b01;
  localparam logic [1:0]  FC_TYPE_DATA   = 2'b10;
  localparam logic [3:0]  FC_SUBTYPE_RTS = 4'b1011;

  localparam logic [3:0]  RATE_6M  = 4'hB;
  localparam logic [3:0]  RATE_12M = 4'hA;
  localparam logic [3:0]  RATE_24M = 4'h9;

  localparam logic [15:0] RTS_LEN = 16'd20;

  function automatic resp_class_t classify(input logic [1:0]  fc_type,
                                           input logic [3:0]  fc_subtype,
                                           input logic [15:0] len);
    if (fc_type == FC_TYPE_MGMT || fc_type == FC_TYPE_DATA)
      return CLS_ACK;
    if (fc_type == FC_TYPE_CTRL && fc_subtype == FC_SUBTYPE_RTS && len == RTS_LEN)
      return CLS_CTS;
    return CLS_NONE;
  endfunction

endpackage

// File: rtl/ack_cts_responder_if.sv
// Response request channel between the responder (master) and the TX core (slave).
interface ack_cts_responder_if;
  logic        resp_req;
  logic        resp_is_cts;
  logic [47:0] resp_ra;
  logic [3:0]  resp_rate;
  logic [15:0] resp_duration;
  logic        resp_pending;
  logic        resp_drop;
  logic        resp_ack;

  modport master (
    output resp_req, resp_is_cts, resp_ra, resp_rate, resp_duration,
           resp_pending, resp_drop,
    input  resp_ack
  );

  modport slave (
    input  resp_req, resp_is_cts, resp_ra, resp_rate, resp_duration,
           resp_pending, resp_drop,
    output resp_ack
  );
endinterface

// File: rtl/ack_cts_responder_rate_n_sym.sv
// Maps the received rate to the highest mandatory response rate not above it,
// together with the OFDM symbol count of a 14-byte control response at that rate.
module resp_rate_n_sym
  import ack_cts_responder_pkg::*;
(
  input  logic [7:0] signal_rate,
  output logic [3:0] resp_rate,
  output logic [2:0] n_sym
);

  logic unused_rate_bits;
  assign unused_rate_bits = ^signal_rate[6:4];

  always_comb begin
    resp_rate = RATE_24M;
    n_sym     = 3'd2;
    if (signal_rate[7]) begin
      case (signal_rate[2:0])
        3'd0:       begin resp_rate = RATE_6M;  n_sym = 3'd6; end
        3'd1, 3'd2: begin resp_rate = RATE_12M; n_sym = 3'd3; end
        default:    begin resp_rate = RATE_24M; n_sym = 3'd2; end
      endcase
    end else begin
      case (signal_rate[3:0])
        4'hB, 4'hF: begin resp_rate = RATE_6M;  n_sym = 3'd6; end
        4'hA, 4'hE: begin resp_rate = RATE_12M; n_sym = 3'd3; end
        default:    begin resp_rate = RATE_24M; n_sym = 3'd2; end
      endcase
    end
  end

endmodule

// File: rtl/ack_cts_responder.sv
// Responding end of RTS/CTS and DATA/ACK: latches the received frame fields,
// waits SIFS on the TSF tick and requests an ACK or CTS from the TX core.
module ack_cts_responder
  import ack_cts_responder_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT_US = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tsf_pulse_1M,
  input  logic        resp_enable,
  input  logic        pkt_header_valid_strobe,
  input  logic [7:0]  signal_rate,
  input  logic [15:0] signal_len,
  input  logic        FC_DI_valid,
  input  logic [1:0]  FC_type,
  input  logic [3:0]  FC_subtype,
  input  logic [15:0] duration,
  input  logic        addr1_valid,
  input  logic [47:0] addr1,
  input  logic        addr2_valid,
  input  logic [47:0] addr2,
  input  logic [47:0] self_mac_addr,
  input  logic        fcs_in_strobe,
  input  logic        fcs_valid,
  input  logic [6:0]  sifs_time,
  input  logic [6:0]  resp_lead_time,
  input  logic [6:0]  preamble_sig_time,
  input  logic [4:0]  ofdm_symbol_time,
  ack_cts_responder_if.master resp
);

  localparam int unsigned    TO_W    = $clog2(RESP_TIMEOUT_US + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RESP_TIMEOUT_US - 1);

  resp_state_t state, state_nxt;
  logic load_frame, load_resp, drop_nxt;

  logic [7:0]  rate_l;
  logic [15:0] len_l;
  logic [1:0]  type_l;
  logic [3:0]  subtype_l;
  logic [15:0] dur_l;
  logic        match_l;
  logic [47:0] ta_l;
  logic        seen_fc, seen_a1, seen_a2;

  logic [6:0]      wait_cnt, wait_load;
  logic [TO_W-1:0] to_cnt;

  logic [3:0]  rate_sel;
  logic [2:0]  n_sym;
  logic [9:0]  resp_time;
  logic [16:0] dur_diff;
  logic [15:0] dur_resp;
  resp_class_t cls;
  logic        qualify;

  logic        is_cts_q, drop_q;
  logic [47:0] ra_q;
  logic [3:0]  rate_q;
  logic [15:0] dur_q;

  resp_rate_n_sym u_rate (
    .signal_rate (rate_l),
    .resp_rate   (rate_sel),
    .n_sym       (n_sym)
  );

  always_comb begin
    cls       = classify(type_l, subtype_l, len_l);
    qualify   = fcs_valid && match_l && (cls != CLS_NONE) && seen_fc && seen_a1 && seen_a2;
    wait_load = (sifs_time > resp_lead_time) ? (sifs_time - resp_lead_time) : '0;
    resp_time = 10'(preamble_sig_time) + 10'(ofdm_symbol_time) * 10'(n_sym);
    dur_diff  = {1'b0, dur_l} - 17'(sifs_time) - 17'(resp_time);
    // dur_l never exceeds 15 bits, so bit 16 flags a negative result
    dur_resp  = dur_diff[16] ? '0 : dur_diff[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_frame = 1'b0;
    load_resp  = 1'b0;
    drop_nxt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pkt_header_valid_strobe && resp_enable) begin
          state_nxt  = ST_RX_FIELDS;
          load_frame = 1'b1;
        end
      end
      ST_RX_FIELDS: begin
        if (pkt_header_valid_strobe) begin
          load_frame = 1'b1;
        end else if (fcs_in_strobe) begin
          if (qualify) begin
            state_nxt = ST_SIFS_WAIT;
            load_resp = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_SIFS_WAIT: begin
        if (wait_cnt == '0) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (resp.resp_ack) begin
          state_nxt = ST_IDLE;
        end else if (tsf_pulse_1M && to_cnt == TO_LAST) begin
          state_nxt = ST_IDLE;
          drop_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_l    <= '0;
      len_l     <= '0;
      type_l    <= '0;
      subtype_l <= '0;
      dur_l     <= '0;
      match_l   <= 1'b0;
      ta_l      <= '0;
      seen_fc   <= 1'b0;
      seen_a1   <= 1'b0;
      seen_a2   <= 1'b0;
    end else if (load_frame) begin
      rate_l    <= signal_rate;
      len_l     <= signal_len;
      type_l    <= '0;
      subtype_l <= '0;
      dur_l     <= '0;
      match_l   <= 1'b0;
      ta_l      <= '0;
      seen_fc   <= 1'b0;
      seen_a1   <= 1'b0;
      seen_a2   <= 1'b0;
    end else if (state == ST_RX_FIELDS) begin
      if (FC_DI_valid) begin
        type_l    <= FC_type;
        subtype_l <= FC_subtype;
        // a set bit 15 marks an AID, not a duration
        dur_l     <= duration[15] ? '0 : duration;
        seen_fc   <= 1'b1;
      end
      if (addr1_valid) begin
        match_l <= (addr1 == self_mac_addr);
        seen_a1 <= 1'b1;
      end
      if (addr2_valid) begin
        ta_l    <= addr2;
        seen_a2 <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      to_cnt   <= '0;
      is_cts_q <= 1'b0;
      ra_q     <= '0;
      rate_q   <= '0;
      dur_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= drop_nxt;
      if (load_resp) begin
        wait_cnt <= wait_load;
        is_cts_q <= (cls == CLS_CTS);
        ra_q     <= ta_l;
        rate_q   <= rate_sel;
        dur_q    <= dur_resp;
      end else if (state == ST_SIFS_WAIT && tsf_pulse_1M && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 7'd1;
      end
      if (state != ST_REQ)   to_cnt <= '0;
      else if (tsf_pulse_1M) to_cnt <= to_cnt + 1'b1;
    end
  end

  assign resp.resp_req      = (state == ST_REQ);
  assign resp.resp_pending  = (state == ST_SIFS_WAIT) || (state == ST_REQ);
  assign resp.resp_is_cts   = is_cts_q;
  assign resp.resp_ra       = ra_q;
  assign resp.resp_rate     = rate_q;
  assign resp.resp_duration = dur_q;
  assign resp.resp_drop     = drop_q;

endmodule

// File: tb/tb_ack_cts_responder.sv
// Directed bench for ack_cts_responder: frames are fed as field strobes and the
// response channel is checked against hand-computed values.
module tb_ack_cts_responder;
  import ack_cts_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        tsf_pulse_1M;
  logic        resp_enable;
  logic        pkt_header_valid_strobe;
  logic [7:0]  signal_rate;
  logic [15:0] signal_len;
  logic        FC_DI_valid;
  logic [1:0]  FC_type;
  logic [3:0]  FC_subtype;
  logic [15:0] duration;
  logic        addr1_valid;
  logic [47:0] addr1;
  logic        addr2_valid;
  logic [47:0] addr2;
  logic [47:0] self_mac_addr;
  logic        fcs_in_strobe;
  logic        fcs_valid;
  logic [6:0]  sifs_time;
  logic [6:0]  resp_lead_time;
  logic [6:0]  preamble_sig_time;
  logic [4:0]  ofdm_symbol_time;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [47:0] SELF  = 48'h02_11_22_33_44_55;
  localparam logic [47:0] OTHER = 48'h02_99_88_77_66_55;
  localparam logic [47:0] TA_A  = 48'h0A_0B_0C_0D_0E_0F;
  localparam logic [47:0] TA_B  = 48'h1C_2D_3E_4F_50_61;
  localparam logic [47:0] TA_C  = 48'h77_66_55_44_33_22;

  ack_cts_responder_if rif ();

  ack_cts_responder #(.RESP_TIMEOUT_US(4)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .tsf_pulse_1M            (tsf_pulse_1M),
    .resp_enable             (resp_enable),
    .pkt_header_valid_strobe (pkt_header_valid_strobe),
    .signal_rate             (signal_rate),
    .signal_len              (signal_len),
    .FC_DI_valid             (FC_DI_valid),
    .FC_type                 (FC_type),
    .FC_subtype              (FC_subtype),
    .duration                (duration),
    .addr1_valid             (addr1_valid),
    .addr1                   (addr1),
    .addr2_valid             (addr2_valid),
    .addr2                   (addr2),
    .self_mac_addr           (self_mac_addr),
    .fcs_in_strobe           (fcs_in_strobe),
    .fcs_valid               (fcs_valid),
    .sifs_time               (sifs_time),
    .resp_lead_time          (resp_lead_time),
    .preamble_sig_time       (preamble_sig_time),
    .ofdm_symbol_time        (ofdm_symbol_time),
    .resp                    (rif)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tsf(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      tsf_pulse_1M = 1'b1;
      step();
      tsf_pulse_1M = 1'b0;
      step();
    end
  endtask

  // Returns one cycle after the cycle carrying fcs_in_strobe.
  task automatic send_frame(input logic [1:0] t, input logic [3:0] st, input logic [15:0] dur,
                            input logic [47:0] a1, input logic [47:0] a2,
                            input logic [7:0] rate, input logic [15:0] len, input logic fok);
    signal_rate = rate;
    signal_len  = len;
    pkt_header_valid_strobe = 1'b1;
    step();
    pkt_header_valid_strobe = 1'b0;
    FC_type = t; FC_subtype = st; duration = dur; FC_DI_valid = 1'b1;
    step();
    FC_DI_valid = 1'b0;
    addr1 = a1; addr1_valid = 1'b1;
    step();
    addr1_valid = 1'b0;
    addr2 = a2; addr2_valid = 1'b1;
    step();
    addr2_valid = 1'b0;
    fcs_valid = fok; fcs_in_strobe = 1'b1;
    step();
    fcs_in_strobe = 1'b0;
    fcs_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    @(negedge clk);
    chk({tag, "_req"},     64'(rif.resp_req),      64'd0);
    chk({tag, "_pending"}, 64'(rif.resp_pending),  64'd0);
    chk({tag, "_is_cts"},  64'(rif.resp_is_cts),   64'd0);
    chk({tag, "_ra"},      64'(rif.resp_ra),       64'd0);
    chk({tag, "_rate"},    64'(rif.resp_rate),     64'd0);
    chk({tag, "_dur"},     64'(rif.resp_duration), 64'd0);
    chk({tag, "_drop"},    64'(rif.resp_drop),     64'd0);
  endtask

  initial begin
    rst = 1'b1;
    tsf_pulse_1M = 1'b0; resp_enable = 1'b1; pkt_header_valid_strobe = 1'b0;
    signal_rate = '0; signal_len = '0; FC_DI_valid = 1'b0; FC_type = '0; FC_subtype = '0;
    duration = '0; addr1_valid = 1'b0; addr1 = '0; addr2_valid = 1'b0; addr2 = '0;
    self_mac_addr = SELF; fcs_in_strobe = 1'b0; fcs_valid = 1'b0;
    sifs_time = 7'd16; resp_lead_time = 7'd2; preamble_sig_time = 7'd20; ofdm_symbol_time = 5'd4;
    rif.resp_ack = 1'b0;
    step(); step(); step();
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Data frame to self at 54 Mb/s: 44 - 16 - (20 + 4*2) = 0, 14 us wait
    send_frame(FC_TYPE_DATA, 4'd0, 16'd44, SELF, TA_A, 8'h0C, 16'd100, 1'b1);
    @(negedge clk);
    chk("ack_pending", 64'(rif.resp_pending),  64'd1);
    chk("ack_req_early", 64'(rif.resp_req),    64'd0);
    chk("ack_is_cts",  64'(rif.resp_is_cts),   64'd0);
    chk("ack_rate",    64'(rif.resp_rate),     64'h9);
    chk("ack_dur",     64'(rif.resp_duration), 64'd0);
    chk("ack_ra",      64'(rif.resp_ra),       64'(TA_A));
    tsf(13);
    tsf_pulse_1M = 1'b1;
    step();
    tsf_pulse_1M = 1'b0;
    @(negedge clk);
    chk("ack_req_at_zero", 64'(rif.resp_req),     64'd0);
    chk("ack_pending_sifs", 64'(rif.resp_pending), 64'd1);
    step();
    @(negedge clk);
    chk("ack_req_rise", 64'(rif.resp_req), 64'd1);
    rif.resp_ack = 1'b1;
    step();
    rif.resp_ack = 1'b0;
    @(negedge clk);
    chk("ack_req_fall",     64'(rif.resp_req),     64'd0);
    chk("ack_pending_fall", 64'(rif.resp_pending), 64'd0);
    chk("ack_no_drop",      64'(rif.resp_drop),    64'd0);
    step();

    // RTS to self at 6 Mb/s: 300 - 16 - (20 + 4*6) = 240; then let it time out
    send_frame(FC_TYPE_CTRL, FC_SUBTYPE_RTS, 16'd300, SELF, TA_B, 8'h0B, 16'd20, 1'b1);
    @(negedge clk);
    chk("cts_pending", 64'(rif.resp_pending),  64'd1);
    chk("cts_is_cts",  64'(rif.resp_is_cts),   64'd1);
    chk("cts_rate",    64'(rif.resp_rate),     64'hB);
    chk("cts_dur",     64'(rif.resp_duration), 64'd240);
    chk("cts_ra",      64'(rif.resp_ra),       64'(TA_B));
    tsf(14);
    @(negedge clk);
    chk("cts_req", 64'(rif.resp_req), 64'd1);
    tsf(3);
    @(negedge clk);
    chk("to_req_held", 64'(rif.resp_req),  64'd1);
    chk("to_no_drop3", 64'(rif.resp_drop), 64'd0);
    tsf_pulse_1M = 1'b1;
    step();
    tsf_pulse_1M = 1'b0;
    @(negedge clk);
    chk("to_drop",    64'(rif.resp_drop),    64'd1);
    chk("to_req_off", 64'(rif.resp_req),     64'd0);
    chk("to_pend_off", 64'(rif.resp_pending), 64'd0);
    step();
    @(negedge clk);
    chk("to_drop_pulse", 64'(rif.resp_drop), 64'd0);

    // Ack coincident with the 4th pulse in REQ wins over the timeout
    send_frame(FC_TYPE_MGMT, 4'd13, 16'd100, SELF, TA_C, 8'h0A, 16'd30, 1'b1);
    tsf(14);
    tsf(3);
    @(negedge clk);
    chk("race_req", 64'(rif.resp_req), 64'd1);
    tsf_pulse_1M = 1'b1;
    rif.resp_ack = 1'b1;
    step();
    tsf_pulse_1M = 1'b0;
    rif.resp_ack = 1'b0;
    @(negedge clk);
    chk("race_no_drop", 64'(rif.resp_drop), 64'd0);
    chk("race_req_off", 64'(rif.resp_req),  64'd0);
    step();
    @(negedge clk);
    chk("race_no_drop2", 64'(rif.resp_drop), 64'd0);

    // Frames that must not be answered
    send_frame(FC_TYPE_DATA, 4'd0, 16'd44, OTHER, TA_A, 8'h0C, 16'd100, 1'b1);
    @(negedge clk);
    chk("other_addr_pending", 64'(rif.resp_pending), 64'd0);
    tsf(15);
    @(negedge clk);
    chk("other_addr_req", 64'(rif.resp_req), 64'd0);
    send_frame(FC_TYPE_DATA, 4'd0, 16'd44, SELF, TA_A, 8'h0C, 16'd100, 1'b0);
    @(negedge clk);
    chk("bad_fcs_pending", 64'(rif.resp_pending), 64'd0);
    send_frame(FC_TYPE_CTRL, FC_SUBTYPE_RTS, 16'd300, SELF, TA_B, 8'h0B, 16'd21, 1'b1);
    @(negedge clk);
    chk("rts_badlen_pending", 64'(rif.resp_pending), 64'd0);
    resp_enable = 1'b0;
    send_frame(FC_TYPE_DATA, 4'd0, 16'd44, SELF, TA_A, 8'h0C, 16'd100, 1'b1);
    @(negedge clk);
    chk("disabled_pending", 64'(rif.resp_pending), 64'd0);
    resp_enable = 1'b1;

    // Header strobe during SIFS_WAIT is ignored; reset clears everything
    send_frame(FC_TYPE_DATA, 4'd0, 16'd44, SELF, TA_A, 8'h0C, 16'd100, 1'b1);
    tsf(2);
    pkt_header_valid_strobe = 1'b1;
    step();
    pkt_header_valid_strobe = 1'b0;
    @(negedge clk);
    chk("sifs_hdr_pending", 64'(rif.resp_pending), 64'd1);
    chk("sifs_hdr_ra",      64'(rif.resp_ra),      64'(TA_A));
    rst = 1'b1;
    step();
    chk_all_zero("mid_rst");
    rst = 1'b0;
    step();

    // HT MCS1 with bit 15 set in the duration field
    send_frame(FC_TYPE_DATA, 4'd8, 16'h8000 | 16'd300, SELF, TA_C, 8'h81, 16'd200, 1'b1);
    @(negedge clk);
    chk("ht_pending", 64'(rif.resp_pending),  64'd1);
    chk("ht_rate",    64'(rif.resp_rate),     64'hA);
    chk("ht_dur",     64'(rif.resp_duration), 64'd0);
    chk("ht_ra",      64'(rif.resp_ra),       64'(TA_C));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
